// File: rtl/mult_div_pkg.sv
// Shared op and state encodings for the sequential multiply/divide unit.
package mult_div_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/md_cond_neg.sv
// Conditional two's-complement negate, purely combinational.
module md_cond_neg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/mult_div_seq.sv
// Sequential signed/unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
module mult_div_seq
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CntInit = CW'(WIDTH);

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_is_div;
  logic                 r_neg_res;
  logic                 r_neg_rem;
  logic [WIDTH-1:0]     r_opnd;
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_div_zero;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_signed;
  logic                 w_op_div;
  logic                 w_b_zero;
  logic                 w_neg_a;
  logic                 w_neg_b;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_div_trial;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;

  assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign w_op_div = (i_op == OP_DIV) || (i_op == OP_DIVU);
  assign w_b_zero = (i_b == '0);
  assign w_neg_a  = w_signed & i_a[WIDTH-1];
  assign w_neg_b  = w_signed & i_b[WIDTH-1];

  md_cond_neg #(.WIDTH(WIDTH)) u_abs_a (.i_neg(w_neg_a), .i_val(i_a), .o_val(w_abs_a));
  md_cond_neg #(.WIDTH(WIDTH)) u_abs_b (.i_neg(w_neg_b), .i_val(i_b), .o_val(w_abs_b));

  // Multiply: r_acc = {partial product, remaining multiplier bits}; carry kept in w_mul_sum[WIDTH].
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: r_acc = {remainder, quotient}; trial uses the shifted remainder plus one extra bit.
  assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
  assign w_div_next  = w_div_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                          : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  md_cond_neg #(.WIDTH(2*WIDTH)) u_fix_prod (
    .i_neg(r_neg_res),
    .i_val(r_acc),
    .o_val(w_prod_fix)
  );
  md_cond_neg #(.WIDTH(WIDTH)) u_fix_quo (
    .i_neg(r_neg_res),
    .i_val(r_acc[WIDTH-1:0]),
    .o_val(w_quo_fix)
  );
  md_cond_neg #(.WIDTH(WIDTH)) u_fix_rem (
    .i_neg(r_neg_rem),
    .i_val(r_acc[2*WIDTH-1:WIDTH]),
    .o_val(w_rem_fix)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_busy <= 1'b1;
            if (w_op_div && w_b_zero) begin
              r_div_zero <= 1'b1;
              r_done     <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_div_zero <= 1'b0;
              r_is_div   <= w_op_div;
              r_neg_res  <= w_neg_a ^ w_neg_b;
              r_neg_rem  <= w_op_div & w_neg_a;
              r_cnt      <= CntInit;
              if (w_op_div) begin
                r_opnd <= w_abs_b;
                r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
              end else begin
                r_opnd <= w_abs_a;
                r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
              end
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= FIX;
        end
        FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_div_zero = r_div_zero;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;

endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq at WIDTH=32.
module tb_mult_div_seq;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t sb_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic prev_done = 1'b0;

  mult_div_seq #(.WIDTH(W)) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_start   (start),
    .i_op      (op),
    .i_a       (a),
    .i_b       (b),
    .o_busy    (busy),
    .o_done    (done),
    .o_div_zero(div_zero),
    .o_hi      (hi),
    .o_lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference built from native 64-bit arithmetic, independent of the iterative datapath.
  function automatic exp_t model(input logic [1:0] mop, input logic [W-1:0] ma,
                                 input logic [W-1:0] mb, input logic [W-1:0] ph,
                                 input logic [W-1:0] pl);
    exp_t        e;
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa   = longint'($signed(ma));
    sb   = longint'($signed(mb));
    e.dz = 1'b0;
    e.hi = ph;
    e.lo = pl;
    case (mop)
      2'b00: begin
        p = 64'(sa * sb);
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      2'b01: begin
        p = {32'b0, ma} * {32'b0, mb};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      2'b10: begin
        if (mb == '0) e.dz = 1'b1;
        else begin
          e.lo = 32'(sa / sb);
          e.hi = 32'(sa % sb);
        end
      end
      default: begin
        if (mb == '0) e.dz = 1'b1;
        else begin
          e.lo = ma / mb;
          e.hi = ma % mb;
        end
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        check_eq("done_single_cycle", 64'(prev_done), 64'(1'b0));
        if (sb_q.size() == 0) begin
          check_eq("spurious_done", 64'(done), 64'(1'b0));
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("hi", 64'(hi), 64'(e.hi));
          check_eq("lo", 64'(lo), 64'(e.lo));
          check_eq("div_zero", 64'(div_zero), 64'(e.dz));
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Drives one request, then checks busy, div_zero and done latency; the monitor checks results.
  task automatic run_op(input logic [1:0] top, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input exp_t e, input bit poke);
    int cycles;
    sb_q.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;
    @(negedge clk);
    start = 1'b1;
    op    = top;
    a     = ta;
    b     = tb;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", 64'(busy), 64'(1'b1));
    check_eq("dz_at_start", 64'(div_zero), 64'(e.dz));
    cycles = 0;
    while (!done && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (!done) check_eq("busy_in_flight", 64'(busy), 64'(1'b1));
      // A second request mid-run must be ignored.
      if (poke && cycles == 5) begin
        start = 1'b1;
        op    = 2'b00;
        a     = 32'h1234_5678;
        b     = 32'h0000_0003;
      end else if (poke && cycles == 6) begin
        start = 1'b0;
      end
    end
    check_eq("done_latency", 64'(cycles), e.dz ? 64'd0 : 64'(W + 1));
    @(negedge clk);
    check_eq("idle_busy", 64'(busy), 64'(1'b0));
  endtask

  function automatic exp_t mk(input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
    exp_t e;
    e.hi = eh;
    e.lo = el;
    e.dz = ed;
    return e;
  endfunction

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'(1'b0));
    check_eq("rst_done", 64'(done), 64'(1'b0));
    check_eq("rst_dz", 64'(div_zero), 64'(1'b0));
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0), 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b0), 1'b0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'h0, 32'h1, 1'b0), 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0), 1'b0);
    run_op(2'b11, 32'd7, 32'd2, mk(32'd1, 32'd3, 1'b0), 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h0, 32'h8000_0000, 1'b0), 1'b0);

    // 0x14 * 0xE6666669 = 0x12_00000034 preloads hi/lo before the divide by zero.
    run_op(2'b01, 32'h0000_0014, 32'hE666_6669, mk(32'h12, 32'h34, 1'b0), 1'b0);
    run_op(2'b11, 32'd99, 32'd0, mk(32'h12, 32'h34, 1'b1), 1'b0);
    run_op(2'b11, 32'd100, 32'd7, mk(32'd2, 32'd14, 1'b0), 1'b0);

    run_op(2'b01, 32'd6, 32'd7, mk(32'd0, 32'd42, 1'b0), 1'b1);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      logic [1:0]   rop;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int unsigned  sel;
      rop = 2'($urandom_range(0, 3));
      ra  = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
      sel = $urandom_range(0, 7);
      rb  = (sel == 0) ? 32'd0 : (sel < 3) ? 32'($urandom_range(1, 300)) : $urandom;
      run_op(rop, ra, rb, model(rop, ra, rb, m_hi, m_lo), 1'b0);
    end

    // Abort mid-run: reset lands on the 10th iteration edge, no done may follow.
    @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    a     = 32'd1000;
    b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", 64'(busy), 64'(1'b0));
    check_eq("abort_done", 64'(done), 64'(1'b0));
    check_eq("abort_hi", 64'(hi), 64'd0);
    check_eq("abort_lo", 64'(lo), 64'd0);
    check_eq("abort_dz", 64'(div_zero), 64'(1'b0));
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("abort_quiet_busy", 64'(busy), 64'(1'b0));
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
